// File: rtl/spi_slave_sync.sv
`timescale 1ns/1ps
// SPI slave oversampled in the clk domain: sck/mosi/cs_n are synchronised and edge-detected,
// never used as clocks. All CPOL/CPHA modes, TX FIFO with valid/ready push, RX word strobe.
//   state    | meaning
//   S_IDLE   | deselected, miso tri-stated, sck edges ignored
//   S_ACTIVE | selected, sampling mosi and shifting tx_shift onto miso
module spi_slave_sync #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TX_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             spi_sck,
  input  logic             spi_mosi,
  input  logic             spi_cs_n,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int   BW     = $clog2(WIDTH);
  localparam int   PW     = $clog2(TX_DEPTH);
  localparam logic P_CPOL = (CPOL != 0);
  localparam logic P_CPHA = (CPHA != 0);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_prev;
  logic                   r_cs_prev;

  state_t                 r_state;
  logic [BW-1:0]          r_bit_cnt;
  logic [WIDTH-1:0]       r_tx_shift;
  logic [WIDTH-2:0]       r_rx_shift;
  logic                   r_load_pend;
  logic                   r_first_lead;
  logic [WIDTH-1:0]       r_rx_data;
  logic                   r_rx_valid;
  logic                   r_tx_underrun;

  logic [WIDTH-1:0]       r_mem [TX_DEPTH];
  logic [PW:0]            r_wr_ptr;
  logic [PW:0]            r_rd_ptr;

  logic                   w_sck_s;
  logic                   w_mosi_s;
  logic                   w_cs_s;
  logic                   w_sck_chg;
  logic                   w_lead;
  logic                   w_trail;
  logic                   w_sample;
  logic                   w_shift;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic                   w_load;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic [WIDTH-1:0]       w_rd_data;
  logic [WIDTH-1:0]       w_rx_next;

  // Synchronisers reset to the idle line levels so no false edge follows reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_sync  <= {SYNC_STAGES{P_CPOL}};
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sck_prev  <= P_CPOL;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sck_prev  <= w_sck_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  assign w_sck_s   = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_chg = w_sck_s ^ r_sck_prev;
  assign w_lead    = w_sck_chg & (r_sck_prev == P_CPOL);
  assign w_trail   = w_sck_chg & (w_sck_s == P_CPOL);
  assign w_sample  = P_CPHA ? w_trail : w_lead;
  assign w_shift   = P_CPHA ? w_lead : w_trail;
  assign w_cs_fall = r_cs_prev & ~w_cs_s;
  assign w_cs_rise = ~r_cs_prev & w_cs_s;
  assign w_rx_next = {r_rx_shift, w_mosi_s};

  // CPHA=0 loads on the trailing edge after the last sample; CPHA=1 loads the cycle after it.
  always_comb begin
    w_load = 1'b0;
    if (r_state == S_IDLE) begin
      w_load = w_cs_fall;
    end else if (!w_cs_rise) begin
      if (P_CPHA) w_load = r_load_pend;
      else        w_load = w_shift & r_load_pend;
    end
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_pop     = w_load & ~w_empty;
  assign tx_ready  = ~w_full | w_pop;
  assign w_push    = tx_valid & tx_ready;
  assign w_rd_data = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_load_pend   <= 1'b0;
      r_first_lead  <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state     <= S_ACTIVE;
            r_bit_cnt   <= '0;
            r_load_pend <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (w_cs_rise) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_load_pend <= 1'b0;
            r_tx_shift  <= '0;
          end else begin
            if (w_sample) begin
              r_rx_shift <= w_rx_next[WIDTH-2:0];
              if (r_bit_cnt == BW'(WIDTH-1)) begin
                r_rx_data   <= w_rx_next;
                r_rx_valid  <= 1'b1;
                r_bit_cnt   <= '0;
                r_load_pend <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
            if (w_shift) begin
              // The first leading edge of a CPHA=1 word only presents the already-loaded MSB.
              if (P_CPHA) begin
                if (r_first_lead) r_first_lead <= 1'b0;
                else              r_tx_shift   <= {r_tx_shift[WIDTH-2:0], 1'b0};
              end else if (!r_load_pend) begin
                r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_load) begin
        r_tx_shift    <= w_empty ? '0 : w_rd_data;
        r_tx_underrun <= w_empty;
        r_load_pend   <= 1'b0;
        r_first_lead  <= 1'b1;
      end
    end
  end

  assign spi_miso    = (r_state == S_ACTIVE) & r_tx_shift[WIDTH-1];
  assign spi_miso_oe = (r_state == S_ACTIVE);
  assign busy        = (r_state == S_ACTIVE);
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_slave_sync.sv
`timescale 1ns/1ps
// Bench for spi_slave_sync: one instance per SPI mode, a bit-level SPI master and a
// word-level FIFO/frame reference model.
module tb_spi_slave_sync;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic       sck [4];
  logic       cs_n [4];
  logic       tx_valid [4];
  logic       miso [4];
  logic       miso_oe [4];
  logic       tx_ready [4];
  logic       rx_valid [4];
  logic       tx_underrun [4];
  logic       busy [4];
  logic [7:0] rx_data [4];

  int         n_cmp = 0;
  int         n_err = 0;

  int         rx_cnt [4]   = '{0, 0, 0, 0};
  int         un_cnt [4]   = '{0, 0, 0, 0};
  int         un_at_rx [4] = '{0, 0, 0, 0};
  logic [7:0] rx_log [4][16];

  logic [7:0] fmem [4][8];
  int         fcnt [4] = '{0, 0, 0, 0};

  logic [7:0] m_tx [8];
  logic [7:0] m_rd [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_sync #(
      .WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2), .TX_DEPTH(4)
    ) u_dut (
      .clk(clk), .resetn(resetn),
      .spi_sck(sck[g]), .spi_mosi(mosi), .spi_cs_n(cs_n[g]),
      .spi_miso(miso[g]), .spi_miso_oe(miso_oe[g]),
      .tx_data(tx_data), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
      .tx_underrun(tx_underrun[g]), .busy(busy[g])
    );
  end

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (tx_underrun[m] === 1'b1) un_cnt[m] <= un_cnt[m] + 1;
      if (rx_valid[m] === 1'b1) begin
        rx_log[m][rx_cnt[m] % 16] <= rx_data[m];
        rx_cnt[m]   <= rx_cnt[m] + 1;
        un_at_rx[m] <= un_cnt[m] + ((tx_underrun[m] === 1'b1) ? 1 : 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input int m, input logic [7:0] d);
    fmem[m][fcnt[m]] = d;
    fcnt[m]++;
  endtask

  task automatic model_pop(input int m, output bit ok, output logic [7:0] d);
    ok = (fcnt[m] > 0);
    d  = fmem[m][0];
    if (ok) begin
      for (int i = 0; i < 7; i++) fmem[m][i] = fmem[m][i+1];
      fcnt[m]--;
    end
  endtask

  task automatic chk_reset_outputs(input int m, input string when);
    chk($sformatf("%s_miso_m%0d", when, m), miso[m], 0);
    chk($sformatf("%s_oe_m%0d", when, m), miso_oe[m], 0);
    chk($sformatf("%s_rxdata_m%0d", when, m), rx_data[m], 0);
    chk($sformatf("%s_rxvalid_m%0d", when, m), rx_valid[m], 0);
    chk($sformatf("%s_underrun_m%0d", when, m), tx_underrun[m], 0);
    chk($sformatf("%s_busy_m%0d", when, m), busy[m], 0);
    chk($sformatf("%s_txready_m%0d", when, m), tx_ready[m], 1);
  endtask

  // Entered on a falling clk edge; sampling the ready line there keeps clear of the active edge.
  task automatic push_word(input int m, input logic [7:0] d);
    logic acc;
    bit   exp;
    tx_data     = d;
    tx_valid[m] = 1'b1;
    acc         = tx_ready[m];
    exp         = (fcnt[m] < 4);
    chk($sformatf("push_ready_m%0d_cnt%0d", m, fcnt[m]), acc, exp);
    @(posedge clk);
    #1;
    tx_valid[m] = 1'b0;
    if (exp) model_push(m, d);
    @(negedge clk);
  endtask

  task automatic spi_xfer(input int m, input int nbits, input bit raise_cs);
    logic cpol, cpha, bit_rd;
    int   w, b;
    cpol    = (m >= 2);
    cpha    = (m % 2 == 1);
    cs_n[m] = 1'b0;
    #(HALF);
    chk($sformatf("busy_sel_m%0d", m), busy[m], 1);
    chk($sformatf("oe_sel_m%0d", m), miso_oe[m], 1);
    for (int i = 0; i < nbits; i++) begin
      w = i / 8;
      b = 7 - (i % 8);
      if (!cpha) begin
        mosi = m_tx[w][b];
        #(HALF);
        bit_rd = miso[m];
        sck[m] = ~cpol;
        #(HALF);
        sck[m] = cpol;
      end else begin
        sck[m] = ~cpol;
        mosi   = m_tx[w][b];
        #(HALF);
        bit_rd = miso[m];
        sck[m] = cpol;
        #(HALF);
      end
      m_rd[w][b] = bit_rd;
    end
    #(HALF);
    if (raise_cs) begin
      cs_n[m] = 1'b1;
      #(HALF);
    end
  endtask

  task automatic push_when_ready(input int m, input logic [7:0] d);
    logic acc;
    tx_data     = d;
    tx_valid[m] = 1'b1;
    acc         = 1'b0;
    for (int c = 0; c < 400 && !acc; c++) begin
      @(negedge clk);
      if (tx_ready[m] === 1'b1) acc = 1'b1;
    end
    @(posedge clk);
    #1;
    tx_valid[m] = 1'b0;
    chk($sformatf("swap_push_accepted_m%0d", m), acc, 1);
    @(negedge clk);
    chk($sformatf("swap_still_full_m%0d", m), tx_ready[m], 0);
  endtask

  // A complete frame loads once per word plus once after the last word.
  task automatic run_frame(input int m, input int n, input bit with_push, input logic [7:0] pdata);
    int         rb, ub, exp_un;
    logic [7:0] exp_rd [8];
    logic [7:0] d;
    bit         ok;
    rb     = rx_cnt[m];
    ub     = un_cnt[m];
    exp_un = 0;
    for (int i = 0; i < n; i++) begin
      model_pop(m, ok, d);
      if (!ok) begin
        d = 8'h00;
        exp_un++;
      end
      exp_rd[i] = d;
      if (i == 0 && with_push) model_push(m, pdata);
    end
    model_pop(m, ok, d);
    if (with_push) begin
      fork
        spi_xfer(m, n * 8, 1'b1);
        push_when_ready(m, pdata);
      join
    end else begin
      spi_xfer(m, n * 8, 1'b1);
    end
    @(negedge clk);
    chk($sformatf("rx_strobes_m%0d", m), rx_cnt[m] - rb, n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("master_read_m%0d_w%0d", m, i), m_rd[i], exp_rd[i]);
      chk($sformatf("rx_word_m%0d_w%0d", m, i), rx_log[m][(rb + i) % 16], m_tx[i]);
    end
    chk($sformatf("underruns_m%0d", m), un_at_rx[m] - ub, exp_un);
    chk($sformatf("busy_after_m%0d", m), busy[m], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         rb, np, nw, md;
    logic [7:0] d;
    bit         ok;
    for (int m = 0; m < 4; m++) begin
      sck[m]      = (m >= 2);
      cs_n[m]     = 1'b1;
      tx_valid[m] = 1'b0;
    end
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) chk_reset_outputs(m, "por");

    push_word(0, 8'hA5);
    m_tx[0] = 8'h3C;
    run_frame(0, 1, 1'b0, 8'h00);
    chk("rx_hold_m0", rx_data[0], 8'h3C);

    m_tx[0] = 8'($urandom);
    m_tx[1] = 8'($urandom);
    run_frame(0, 2, 1'b0, 8'h00);

    for (int m = 1; m < 4; m++) begin
      push_word(m, 8'h11);
      push_word(m, 8'h22);
      push_word(m, 8'h33);
      for (int i = 0; i < 3; i++) m_tx[i] = 8'h96;
      run_frame(m, 3, 1'b0, 8'h00);
    end

    rb = rx_cnt[0];
    push_word(0, 8'h5A);
    m_tx[0] = 8'($urandom);
    model_pop(0, ok, d);
    spi_xfer(0, 5, 1'b1);
    @(negedge clk);
    chk("abort_no_rx", rx_cnt[0] - rb, 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_partial_read", m_rd[0][7:3], 5'b01011);
    push_word(0, 8'hC3);
    m_tx[0] = 8'h81;
    run_frame(0, 1, 1'b0, 8'h00);

    for (int k = 0; k < 5; k++) begin
      push_word(0, 8'hC0 | 8'(k));
      if (k == 3) chk("full_after_4", tx_ready[0], 0);
    end
    for (int i = 0; i < 5; i++) m_tx[i] = 8'($urandom);
    run_frame(0, 5, 1'b1, 8'hE7);

    repeat (12) begin
      md = $urandom_range(0, 3);
      np = $urandom_range(0, 5);
      nw = $urandom_range(1, 4);
      for (int i = 0; i < np; i++) push_word(md, 8'($urandom));
      for (int i = 0; i < nw; i++) m_tx[i] = 8'($urandom);
      run_frame(md, nw, 1'b0, 8'h00);
    end

    push_word(0, 8'h77);
    m_tx[0] = 8'($urandom);
    spi_xfer(0, 3, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    for (int m = 0; m < 4; m++) chk_reset_outputs(m, "midrst");
    cs_n[0] = 1'b1;
    sck[0]  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int m = 0; m < 4; m++) fcnt[m] = 0;
    repeat (3) @(negedge clk);
    chk("txready_after_release", tx_ready[0], 1);
    chk("busy_after_release", busy[0], 0);
    push_word(0, 8'h5C);
    m_tx[0] = 8'($urandom);
    run_frame(0, 1, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
